piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the fixed 4-bit PISO shift register.
- Adds configurable width, MSB/LSB-first order, a valid/ready load handshake, framing status (busy, last) and gapless back-to-back words.
- Sits between a word-wide producer and a single-bit serial link (UART/SPI-style TX datapaths in the sequential library).

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- LSB_FIRST, 0: bit order. 0 = MSB transmitted first; 1 = LSB transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  producer has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- parallel_in  input  WIDTH  word to serialize; sampled only on handshake.
- serial_out  output  1  current serial bit; registered.
- serial_valid  output  1  serial_out carries a data or frame bit this cycle.
- busy  output  1  a word is being shifted out.
- last  output  1  high during the final bit of a frame.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high.
  - All state is updated on the rising edge of clk only.
- Reset values:
  - serial_out=0, serial_valid=0, busy=0, last=0.
  - State IDLE; shift register and bit counter cleared.
  - load_ready=1 in the cycle after reset deasserts.
- States:
  - IDLE: serial_valid=0, serial_out=0.
  - SHIFT: one frame bit per cycle.
- Handshake:
  - A word is accepted at edge E when load_valid && load_ready.
  - load_ready = (state==IDLE) || last; combinational from registered state only, with no path from load_valid.
  - A word is never accepted while busy && !last; load_valid in those cycles is ignored.
- Timing:
  - First bit appears on serial_out in the cycle following E.
  - Frame length F = WIDTH (WIDTH+1 with PARITY_EN).
  - Bits are held for exactly one cycle each, with serial_valid=1 and busy=1.
  - last=1 only in bit F-1.
- Transitions:
  - IDLE -> SHIFT on handshake.
  - SHIFT -> SHIFT on handshake during last: back-to-back, zero idle cycles between frames.
  - SHIFT -> IDLE after last with no handshake; serial_valid falls the next cycle.
- Bit order:
  - LSB_FIRST=0: bit WIDTH-1 first, then down to bit 0.
  - LSB_FIRST=1: bit 0 first, then up to bit WIDTH-1.
- Bit counter:
  - Width $clog2(F+1); counts 0..F-1; never wraps past F-1.
- parallel_in changes outside the handshake cycle have no effect on the frame in flight.
- Reset mid-frame:
  - Frame is aborted immediately.
  - All outputs return to reset values the following cycle.
  - No partial frame is resumed.
- Simultaneous reset and load_valid: reset wins; the word is not accepted.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the accepted word) is appended after the data bits; F=WIDTH+1.
  - Parity is computed at the handshake and stored.
  - last marks the parity bit.
- Undefined: no parity logic or storage is present; F=WIDTH.

Decomposition:
- Shared package/header piso_pkg:
  - State encoding constants (ST_IDLE, ST_SHIFT).
  - Counter-width helper function.
  - Frame-length localparam expression.
- One natural sub-module, piso_bit_counter: load/clear/enable counter with a terminal-count flag that drives last.
- Shift register and FSM stay in the top.

Test Plan:
- WIDTH=8, LSB_FIRST=0: reset 2 cycles, load 8'hB5 -> serial_out 1,0,1,1,0,1,0,1 on 8 consecutive cycles; last only on the 8th; then serial_valid=0.
- LSB_FIRST=1: load 8'hB5 -> serial_out 1,0,1,0,1,1,0,1.
- Back-to-back: load_valid held with 8'hB5, then 8'h3C presented during last -> 16 contiguous valid bits (MSB-first 10110101 00111100), no gap, busy never drops.
- Load while busy: pulse load_valid with 8'hFF at bit 3 of an 8'h00 frame -> ignored, all 8 bits 0, load_ready=0 at that cycle.
- Reset mid-frame: assert reset at bit 4 of 8'hB5 -> next cycle serial_valid=0, busy=0, serial_out=0, load_ready=1 after release.
- PISO_PARITY_EN defined: load 8'hB5 -> 9 bits 1,0,1,1,0,1,0,1,1 (parity 1, five ones); last on 9th.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding, frame length and counter sizing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits per frame: the data word plus the optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Counter wide enough to hold 0..frame_len.
  function automatic int cnt_width(input int flen);
    return $clog2(flen + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the PISO serializer.
// master = word producer / link consumer, slave = the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             last;

  modport master (
    output load_valid, parallel_in,
    input  load_ready, serial_out, serial_valid, busy, last
  );

  modport slave (
    input  load_valid, parallel_in,
    output load_ready, serial_out, serial_valid, busy, last
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: restarts at 0 on load, advances while enabled, stops at FRAME_LEN-1.
// tc flags the final bit position of the frame.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(FRAME_LEN);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(FRAME_LEN - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load || clear) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load and gapless back-to-back frames.
// Optional even parity after the data bits when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               reset,
  piso_serializer_if.slave  bus
);

  localparam int F = frame_len(WIDTH);

  state_e         state_q, state_d;
  logic [F-1:0]   shreg_q, shreg_d;
  logic           tc;
  logic           last_bit;
  logic           load_ready;
  logic           handshake;

  // The frame is laid out so the next bit always sits at the output end of the register;
  // zeros shift in behind it, which leaves the register clear once the frame is out.
  function automatic logic [F-1:0] build_frame(input logic [WIDTH-1:0] word);
`ifdef PISO_PARITY_EN
    logic par;
    par = ^word;
    if (LSB_FIRST) return {par, word};
    else           return {word, par};
`else
    return word;
`endif
  endfunction

  function automatic logic [F-1:0] shift_frame(input logic [F-1:0] frame);
    if (LSB_FIRST) return {1'b0, frame[F-1:1]};
    else           return {frame[F-2:0], 1'b0};
  endfunction

  assign last_bit   = (state_q == ST_SHIFT) && tc;
  // Ready depends on registered state only, never on load_valid.
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign handshake  = bus.load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_SHIFT;
          shreg_d = build_frame(bus.parallel_in);
        end
      end
      ST_SHIFT: begin
        if (handshake) begin
          shreg_d = build_frame(bus.parallel_in);
        end else if (last_bit) begin
          state_d = ST_IDLE;
          shreg_d = '0;
        end else begin
          shreg_d = shift_frame(shreg_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  piso_bit_counter #(
    .FRAME_LEN (F)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (handshake),
    .clear (last_bit && !handshake),
    .en    (state_q == ST_SHIFT),
    .tc    (tc)
  );

  assign bus.load_ready   = load_ready;
  assign bus.serial_out   = LSB_FIRST ? shreg_q[0] : shreg_q[F-1];
  assign bus.serial_valid = (state_q == ST_SHIFT);
  assign bus.busy         = (state_q == ST_SHIFT);
  assign bus.last         = last_bit;

endmodule
